fsqrt_issue_ctrl: RTL and testbench



---
 rtl/fsqrt_issue_pkg.sv | 20 ++
 rtl/fsqrt_rsp_fifo.sv | 59 +++++
 rtl/fsqrt_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_fsqrt_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsqrt_issue_pkg.sv
// Shared types for the fsqrt issue/collect controller: tag-pipe entries and
// result-FIFO entries.
package fsqrt_issue_pkg;

    localparam int DEF_TAG_W      = 5;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int FIFO_AW        = $clog2(DEF_FIFO_DEPTH);

    typedef struct packed {
        logic                 occ;
        logic                 live;
        logic [DEF_TAG_W-1:0] tag;
    } tag_ent_t;

    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [31:0]          y;
    } rsp_ent_t;

endpackage

// File: rtl/fsqrt_rsp_fifo.sv
// Result FIFO for the fsqrt controller: register-array storage, head read
// straight from the array, synchronous clear and occupancy count.
module fsqrt_rsp_fifo
    import fsqrt_issue_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          rstn,
    input  logic          clr_i,
    input  logic          push_i,
    input  rsp_ent_t      push_data_i,
    input  logic          pop_i,
    output rsp_ent_t      head_o,
    output logic [AW:0]   count_o,
    output logic          empty_o
);

    rsp_ent_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// Issue/collect controller for the non-stallable fsqrt unit. Credits reserve a
// FIFO slot per live op. Define FSQRT_ISSUE_CHK_EN to add the sticky err output.
module fsqrt_issue_ctrl
    import fsqrt_issue_pkg::*;
#(
    parameter int LATENCY    = 3,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_x,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             fu_valid,
    output logic [31:0]      fu_x,
    input  logic [31:0]      fu_y,
    input  logic             fu_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
`ifdef FSQRT_ISSUE_CHK_EN
    ,
    output logic             err
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LCW = $clog2(LATENCY + 1);

    tag_ent_t       pipe_q [LATENCY];
    tag_ent_t       pipe_d [LATENCY];
    tag_ent_t       last;
    logic           rdy_en_q;
    logic [LCW-1:0] live_cnt;
    logic [31:0]    credit_sum;
    logic [AW:0]    fifo_cnt;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    rsp_ent_t       push_ent;
    rsp_ent_t       head;

    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < LATENCY; i++) live_cnt = live_cnt + LCW'(pipe_q[i].live);
    end

    // Every live op already owns a FIFO slot, so a returning result always fits.
    assign credit_sum = 32'(fifo_cnt) + 32'(live_cnt);
    assign req_ready  = rdy_en_q & ~flush & (credit_sum < 32'(FIFO_DEPTH));
    assign fu_valid   = req_valid & req_ready;
    assign fu_x       = req_x;

    assign last     = pipe_q[LATENCY-1];
    assign push     = fu_out_valid & last.occ & last.live;
    assign pop      = rsp_valid & rsp_ready;
    assign push_ent = '{tag: last.tag, y: fu_y};

    // occ survives a flush so the killed results still line up and get dropped.
    always_comb begin
        pipe_d[0].occ  = fu_valid;
        pipe_d[0].live = fu_valid;
        pipe_d[0].tag  = req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i]      = pipe_q[i-1];
            pipe_d[i].live = pipe_q[i-1].live & ~flush;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
            rdy_en_q <= 1'b1;
        end
    end

    fsqrt_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .clr_i       (flush),
        .push_i      (push),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_cnt),
        .empty_o     (fifo_empty)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_y     = head.y;
    assign rsp_tag   = head.tag;
    assign busy      = (live_cnt != '0) | ~fifo_empty;

`ifdef FSQRT_ISSUE_CHK_EN
    logic err_q;
    logic fifo_full;
    logic chk_fire;

    assign fifo_full = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign chk_fire  = (fu_out_valid != last.occ) | (push & fifo_full);
    assign err       = err_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_q | chk_fire;
    end

    always @(posedge sys_clk) begin
        if (rstn) assert (!chk_fire);
    end
`endif

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Bench for fsqrt_issue_ctrl: stub unit (y = x + 1, 3-cycle latency), directed
// scenarios, then random traffic checked against a queue-based reference model.
module tb_fsqrt_issue_ctrl;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_x;
    logic [4:0]  req_tag;
    logic        flush;
    logic        fu_valid;
    logic [31:0] fu_x;
    logic [31:0] fu_y;
    logic        fu_out_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic [4:0]  rsp_tag;
    logic        busy;
`ifdef FSQRT_ISSUE_CHK_EN
    logic        err;
`endif

    fsqrt_issue_ctrl #(.LATENCY(LAT), .TAG_W(5), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_tag      (req_tag),
        .flush        (flush),
        .fu_valid     (fu_valid),
        .fu_x         (fu_x),
        .fu_y         (fu_y),
        .fu_out_valid (fu_out_valid),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_y        (rsp_y),
        .rsp_tag      (rsp_tag),
        .busy         (busy)
`ifdef FSQRT_ISSUE_CHK_EN
        ,
        .err          (err)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Stub unit: returns x + 1 exactly LAT cycles after its accept cycle.
    logic [LAT-1:0] v_sh = '0;
    logic [31:0]    x_sh [LAT];
    logic           spur = 1'b0;

`ifdef FSQRT_ISSUE_CHK_EN
    always @(posedge sys_clk or negedge rstn) if (!rstn) v_sh <= '0; else begin
`else
    always @(posedge sys_clk) begin
`endif
        v_sh    <= {v_sh[LAT-2:0], fu_valid};
        x_sh[0] <= fu_x;
        for (int i = 1; i < LAT; i++) x_sh[i] <= x_sh[i-1];
    end

    assign fu_out_valid = v_sh[LAT-1] | spur;
    assign fu_y         = x_sh[LAT-1] + 32'd1;

    // Reference model: in-flight ops with their age, plus the response queue.
    typedef struct { logic [4:0] tag; logic [31:0] y; int age; bit live; } fl_t;
    typedef struct { logic [4:0] tag; logic [31:0] y; } rs_t;
    fl_t infl [$];
    rs_t mfifo [$];
    bit  m_rst_ok = 1'b0;

    int checks = 0;
    int errors = 0;

    logic        s_ready, s_fuv, s_rspv, s_busy;
    logic [31:0] s_y;
    logic [4:0]  s_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step(input bit rv, input logic [31:0] x, input logic [4:0] tg,
                        input bit fl, input bit rr);
        int  live_n;
        bit  e_rdy;
        bit  e_rspv;
        rs_t r;
        @(negedge sys_clk);
        req_valid = rv; req_x = x; req_tag = tg; flush = fl; rsp_ready = rr;
        #1;
        live_n = 0;
        foreach (infl[i]) if (infl[i].live) live_n++;
        e_rdy  = m_rst_ok && !fl && (mfifo.size() + live_n < DEPTH);
        e_rspv = (mfifo.size() > 0);
        s_ready = req_ready; s_fuv = fu_valid; s_rspv = rsp_valid;
        s_busy = busy; s_y = rsp_y; s_tag = rsp_tag;
        chk("req_ready", req_ready, e_rdy);
        chk("fu_valid", fu_valid, rv & e_rdy);
        chk("fu_x", fu_x, x);
        chk("rsp_valid", rsp_valid, e_rspv);
        chk("busy", busy, (live_n > 0) || e_rspv);
        if (e_rspv) begin
            chk("rsp_y", rsp_y, mfifo[0].y);
            chk("rsp_tag", rsp_tag, mfifo[0].tag);
        end
        @(posedge sys_clk);
        m_rst_ok = 1'b1;
        if (e_rspv && rr) void'(mfifo.pop_front());
        if (infl.size() > 0 && infl[0].age == LAT) begin
            if (infl[0].live && !fl) begin
                r.tag = infl[0].tag; r.y = infl[0].y;
                mfifo.push_back(r);
            end
            void'(infl.pop_front());
        end
        if (fl) begin
            mfifo.delete();
            foreach (infl[i]) infl[i].live = 1'b0;
        end
        foreach (infl[i]) infl[i].age++;
        if (rv && e_rdy) infl.push_back('{tag: tg, y: x + 32'd1, age: 1, live: 1'b1});
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 32'h0, 5'd0, 1'b0, rr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic [4:0] got [$];
        rstn = 1'b0; req_valid = 1'b1; req_x = '0; req_tag = '0; flush = 1'b0; rsp_ready = 1'b0;
        #3;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_fu_valid", fu_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_y", rsp_y, 32'h0);
        chk("rst_rsp_tag", rsp_tag, 5'h0);
        chk("rst_busy", busy, 1'b0);
        req_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rstn = 1'b1;
        #1;
        chk("pre_edge_ready", req_ready, 1'b0);
        @(posedge sys_clk);
        m_rst_ok = 1'b1;

        // single op: latency LAT+1 to response
        step(1'b1, 32'h40800000, 5'd7, 1'b0, 1'b0);
        chk("single_fu_valid", s_fuv, 1'b1);
        repeat (3) idle(1'b0);
        chk("single_rspv_c3", s_rspv, 1'b0);
        idle(1'b1);
        chk("single_rspv_c4", s_rspv, 1'b1);
        chk("single_y", s_y, 32'h40800001);
        chk("single_tag", s_tag, 5'd7);
        idle(1'b0);
        chk("single_busy_done", s_busy, 1'b0);

        // back-to-back until credits run out, then recover
        for (int t = 1; t <= 4; t++) begin
            step(1'b1, 32'(t * 16), 5'(t), 1'b0, 1'b0);
            chk("b2b_ready", s_ready, 1'b1);
        end
        step(1'b1, 32'h99, 5'd5, 1'b0, 1'b0);
        chk("b2b_full_ready", s_ready, 1'b0);
        chk("b2b_full_fuv", s_fuv, 1'b0);
        repeat (2) idle(1'b0);
        idle(1'b1);
        chk("b2b_head_tag", s_tag, 5'd1);
        step(1'b1, 32'h55, 5'd5, 1'b0, 1'b0);
        chk("recover_ready", s_ready, 1'b1);
        for (int n = 0; n < 20; n++) begin
            idle(1'b1);
            if (s_rspv) got.push_back(s_tag);
        end
        chk("drain_count", 64'(got.size()), 64'd4);
        for (int n = 0; n < got.size() && n < 4; n++) chk("drain_order", got[n], 5'(n + 2));
        chk("drain_busy", s_busy, 1'b0);

        // flush mid-flight
        step(1'b1, 32'h10, 5'd1, 1'b0, 1'b0);
        step(1'b1, 32'h20, 5'd2, 1'b0, 1'b0);
        step(1'b1, 32'h30, 5'd3, 1'b1, 1'b0);
        chk("flush_ready", s_ready, 1'b0);
        chk("flush_fuv", s_fuv, 1'b0);
        idle(1'b0);
        chk("flush_busy", s_busy, 1'b0);
        for (int n = 0; n < 3; n++) begin
            idle(1'b0);
            chk("flush_rspv", s_rspv, 1'b0);
        end

        // asynchronous reset with work buffered and in flight
        step(1'b1, 32'h100, 5'd9, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        step(1'b1, 32'h200, 5'd10, 1'b0, 1'b0);
        step(1'b1, 32'h300, 5'd11, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_fu_valid", fu_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", req_ready, 1'b0);
        infl.delete(); mfifo.delete(); m_rst_ok = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rstn = 1'b1; req_valid = 1'b0;
        @(posedge sys_clk);
        m_rst_ok = 1'b1;
        for (int n = 0; n < 6; n++) begin
            idle(1'b1);
            chk("post_rst_rspv", s_rspv, 1'b0);
        end
`ifdef FSQRT_ISSUE_CHK_EN
        chk("post_rst_err", err, 1'b0);
        @(negedge sys_clk);
        spur = 1'b1;
        @(posedge sys_clk);
        #1 spur = 1'b0;
        chk("err_set", err, 1'b1);
        repeat (3) @(posedge sys_clk);
        #1 chk("err_sticky", err, 1'b1);
`endif

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1);
        end
        repeat (10) idle(1'b1);
        chk("final_busy", s_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
